ddfs_sweep_ctrl: RTL and testbench

Frequency scheduler that drives the 23-bit fcontrol tuning word of the ddfs core.
Software loads a small register file, then issues start. The block then sequences the word: fixed tone, single linear sweep, looping sweep, or hopping through a table.
It sits between the host config bus and ddfs.fcontrol, and owns all tuning-word timing.

---
 rtl/ddfs_pkg.sv | 29 ++
 rtl/ddfs_hop_table.sv | 36 +++
 rtl/ddfs_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ddfs_sweep_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared types and constants for the ddfs tuning-word scheduler.
// Holds the mode and state encodings and config register addresses.
package ddfs_pkg;

  localparam int FW = 23;

  typedef enum logic [1:0] {
    MODE_FIXED      = 2'd0,
    MODE_SWEEP_ONCE = 2'd1,
    MODE_SWEEP_LOOP = 2'd2,
    MODE_HOP        = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_START_F      = 3'd0;
  localparam logic [2:0] ADDR_STOP_F       = 3'd1;
  localparam logic [2:0] ADDR_STEP_F       = 3'd2;
  localparam logic [2:0] ADDR_DWELL        = 3'd3;
  localparam logic [2:0] ADDR_MODE         = 3'd4;
  localparam logic [2:0] ADDR_HOP_LEN      = 3'd5;
  localparam logic [2:0] ADDR_HOP_DATA     = 3'd6;
  localparam logic [2:0] ADDR_HOP_WPTR_CLR = 3'd7;

endpackage

// File: rtl/ddfs_hop_table.sv
// Hop-frequency register file: auto-incrementing write pointer,
// pointer clear, and combinational read by index.
module ddfs_hop_table #(
  parameter int FW    = 23,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic                     clr_i,
  input  logic [FW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [FW-1:0]            rd_data_o
);

  localparam int IW = $clog2(DEPTH);

  logic [FW-1:0] mem_q [DEPTH];
  logic [IW-1:0] wptr_q;

  // DEPTH is a power of two, so the pointer wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
    end else if (we_i) begin
      mem_q[wptr_q] <= wdata_i;
      wptr_q        <= wptr_q + 1'b1;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Tuning-word scheduler for ddfs.fcontrol: fixed tone, single or
// looping linear sweep, or table hopping, each point held DWELL cycles.
module ddfs_sweep_ctrl #(
  parameter int FW        = ddfs_pkg::FW,
  parameter int DWELL_W   = 16,
  parameter int HOP_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [FW-1:0] cfg_wdata,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] fcontrol,
  output logic          fcontrol_upd,
  output logic          busy,
  output logic          done,
  output logic          cfg_drop
);

  import ddfs_pkg::*;

  localparam int IW = $clog2(HOP_DEPTH);
  localparam int LW = IW + 1;

  state_e             state_q, state_d;
  logic [FW-1:0]      fc_q, fc_d;
  logic               upd_q, upd_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               drop_q;

  logic [FW-1:0]      start_f_q, stop_f_q, step_f_q;
  logic [DWELL_W-1:0] dwell_q;
  mode_e              mode_q;
  logic [LW-1:0]      hop_len_q;

  logic               cfg_acc;
  logic [DWELL_W-1:0] cnt_load;
  logic [LW-1:0]      hop_len_eff;
  logic [LW-1:0]      idx_inc;
  logic [IW-1:0]      idx_nxt;
  logic [IW-1:0]      rd_idx;
  logic [FW-1:0]      hop_rd;
  logic [FW:0]        sum;
  logic               step_ok;

  assign cfg_acc = cfg_we && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_f_q <= '0;
      stop_f_q  <= '0;
      step_f_q  <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_FIXED;
      hop_len_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= cfg_we && (state_q != ST_IDLE);
      if (cfg_acc) begin
        case (cfg_addr)
          ADDR_START_F: start_f_q <= cfg_wdata;
          ADDR_STOP_F:  stop_f_q  <= cfg_wdata;
          ADDR_STEP_F:  step_f_q  <= cfg_wdata;
          ADDR_DWELL:   dwell_q   <= cfg_wdata[DWELL_W-1:0];
          ADDR_MODE:    mode_q    <= mode_e'(cfg_wdata[1:0]);
          ADDR_HOP_LEN: hop_len_q <= cfg_wdata[LW-1:0];
          default: ;
        endcase
      end
    end
  end

  ddfs_hop_table #(
    .FW    (FW),
    .DEPTH (HOP_DEPTH)
  ) u_hop (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (cfg_acc && (cfg_addr == ADDR_HOP_DATA)),
    .clr_i     (cfg_acc && (cfg_addr == ADDR_HOP_WPTR_CLR)),
    .wdata_i   (cfg_wdata),
    .rd_idx_i  (rd_idx),
    .rd_data_o (hop_rd)
  );

  // zero lengths behave as one; oversize hop lengths clamp to the table
  assign cnt_load = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
  assign hop_len_eff =
    (hop_len_q == '0) ? LW'(1) :
    (hop_len_q > LW'(HOP_DEPTH)) ? LW'(HOP_DEPTH) : hop_len_q;
  assign idx_inc = {1'b0, idx_q} + 1'b1;
  assign idx_nxt = (idx_inc >= hop_len_eff) ? '0 : idx_inc[IW-1:0];
  assign rd_idx  = (state_q == ST_IDLE) ? '0 : idx_nxt;

  // one extra bit so a sweep past the top of the range never wraps
  assign sum     = {1'b0, fc_q} + {1'b0, step_f_q};
  assign step_ok = (step_f_q != '0) && (sum <= {1'b0, stop_f_q});

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    upd_d   = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          upd_d   = 1'b1;
          cnt_d   = cnt_load;
          idx_d   = '0;
          fc_d    = (mode_q == MODE_HOP) ? hop_rd : start_f_q;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          cnt_d = cnt_load;
          unique case (mode_q)
            MODE_FIXED: ;
            MODE_SWEEP_ONCE: begin
              if (step_ok) begin
                fc_d  = sum[FW-1:0];
                upd_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end
            MODE_SWEEP_LOOP: begin
              fc_d  = step_ok ? sum[FW-1:0] : start_f_q;
              upd_d = 1'b1;
            end
            MODE_HOP: begin
              idx_d = idx_nxt;
              fc_d  = hop_rd;
              upd_d = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fc_q    <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign fcontrol     = fc_q;
  assign fcontrol_upd = upd_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign cfg_drop     = drop_q;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Scoreboard bench for ddfs_sweep_ctrl: expected upd/done/drop events
// are queued with their cycle stamps and matched by a monitor.
`timescale 1ns/1ps
module tb_ddfs_sweep_ctrl;

  localparam int FW = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [FW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] fcontrol;
  logic          fcontrol_upd, busy, done, cfg_drop;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int s;

  typedef struct {
    logic [FW-1:0] val;
    int            cyc;
  } ev_t;

  ev_t upd_q[$];
  ev_t done_q[$];
  ev_t drop_q[$];

  ddfs_sweep_ctrl #(
    .FW(FW), .DWELL_W(16), .HOP_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .abort        (abort),
    .fcontrol     (fcontrol),
    .fcontrol_upd (fcontrol_upd),
    .busy         (busy),
    .done         (done),
    .cfg_drop     (cfg_drop)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h",
               nm, cyc, act, req);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL unexpected_%s @cyc %0d: got event, required none",
             nm, cyc);
  endtask

  task automatic exp_upd(input logic [FW-1:0] v, input int c);
    upd_q.push_back('{val: v, cyc: c});
  endtask

  task automatic exp_done(input logic [FW-1:0] v, input int c);
    done_q.push_back('{val: v, cyc: c});
  endtask

  task automatic wr(input logic [2:0] a, input logic [FW-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (fcontrol_upd) begin
        if (upd_q.size() == 0) miss("upd");
        else begin
          e = upd_q.pop_front();
          chk("upd_val", 32'(fcontrol), 32'(e.val));
          chk("upd_cyc", cyc, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) miss("done");
        else begin
          e = done_q.pop_front();
          chk("done_val", 32'(fcontrol), 32'(e.val));
          chk("done_cyc", cyc, e.cyc);
        end
      end
      if (cfg_drop) begin
        if (drop_q.size() == 0) miss("drop");
        else begin
          e = drop_q.pop_front();
          chk("drop_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // reset held with start asserted
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_fc", 32'(fcontrol), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_upd", 32'(fcontrol_upd), 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_fc", 32'(fcontrol), 0);

    // single sweep
    wr(3'd0, 23'h006000);
    wr(3'd2, 23'h001000);
    wr(3'd1, 23'h00A000);
    wr(3'd3, 23'd4);
    wr(3'd4, 23'd1);
    s = cyc;
    exp_upd(23'h006000, s + 1);
    exp_upd(23'h007000, s + 5);
    exp_upd(23'h008000, s + 9);
    exp_upd(23'h009000, s + 13);
    exp_upd(23'h00A000, s + 17);
    exp_done(23'h00A000, s + 21);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sweep_busy", 32'(busy), 1);
    repeat (21) @(negedge clk);
    chk("sweep_end_busy", 32'(busy), 0);
    chk("sweep_end_fc", 32'(fcontrol), 32'h00A000);

    // looping sweep near the top of the range
    wr(3'd0, 23'h7FF000);
    wr(3'd2, 23'h000800);
    wr(3'd1, 23'h7FFFFF);
    wr(3'd3, 23'd2);
    wr(3'd4, 23'd2);
    s = cyc;
    exp_upd(23'h7FF000, s + 1);
    exp_upd(23'h7FF800, s + 3);
    exp_upd(23'h7FF000, s + 5);
    exp_upd(23'h7FF800, s + 7);
    exp_upd(23'h7FF000, s + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("loop_abort_busy", 32'(busy), 0);
    chk("loop_abort_fc", 32'(fcontrol), 32'h7FF000);
    repeat (4) @(negedge clk);
    chk("loop_idle_fc", 32'(fcontrol), 32'h7FF000);

    // hop table
    wr(3'd7, 23'd0);
    wr(3'd6, 23'h100000);
    wr(3'd6, 23'h00C000);
    wr(3'd6, 23'h01C000);
    wr(3'd5, 23'd3);
    wr(3'd3, 23'd5);
    wr(3'd4, 23'd3);
    s = cyc;
    exp_upd(23'h100000, s + 1);
    exp_upd(23'h00C000, s + 6);
    exp_upd(23'h01C000, s + 11);
    exp_upd(23'h100000, s + 16);
    exp_upd(23'h00C000, s + 21);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("hop_abort_busy", 32'(busy), 0);
    chk("hop_abort_fc", 32'(fcontrol), 32'h00C000);
    repeat (6) @(negedge clk);
    chk("hop_frozen_fc", 32'(fcontrol), 32'h00C000);

    // config write while busy is dropped
    wr(3'd4, 23'd0);
    wr(3'd0, 23'h123456);
    wr(3'd3, 23'd3);
    s = cyc;
    exp_upd(23'h123456, s + 1);
    drop_q.push_back('{val: '0, cyc: s + 4});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    wr(3'd0, 23'h654321);
    repeat (6) @(negedge clk);
    chk("fixed_busy", 32'(busy), 1);
    chk("fixed_fc", 32'(fcontrol), 32'h123456);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("fixed_abort_busy", 32'(busy), 0);
    s = cyc;
    exp_upd(23'h123456, s + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_old_start", 32'(fcontrol), 32'h123456);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("rerun_abort_busy", 32'(busy), 0);

    // DWELL=0 gives one-cycle points
    wr(3'd4, 23'd1);
    wr(3'd0, 23'h000010);
    wr(3'd2, 23'h000010);
    wr(3'd1, 23'h000030);
    wr(3'd3, 23'd0);
    s = cyc;
    exp_upd(23'h000010, s + 1);
    exp_upd(23'h000020, s + 2);
    exp_upd(23'h000030, s + 3);
    exp_done(23'h000030, s + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("dw0_busy", 32'(busy), 0);

    // STEP=0: start point for one dwell then done
    wr(3'd2, 23'd0);
    wr(3'd3, 23'd3);
    s = cyc;
    exp_upd(23'h000010, s + 1);
    exp_done(23'h000010, s + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("step0_busy", 32'(busy), 0);
    chk("step0_fc", 32'(fcontrol), 32'h000010);

    // HOP_LEN=0 acts as 1: hop[0] re-issued every cycle
    wr(3'd5, 23'd0);
    wr(3'd3, 23'd0);
    wr(3'd4, 23'd3);
    s = cyc;
    exp_upd(23'h100000, s + 1);
    exp_upd(23'h100000, s + 2);
    exp_upd(23'h100000, s + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("hl0_busy", 32'(busy), 0);
    chk("hl0_fc", 32'(fcontrol), 32'h100000);

    // start and abort together from IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("sa_busy_later", 32'(busy), 0);

    repeat (2) @(negedge clk);
    chk("upd_q_empty", upd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("drop_q_empty", drop_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
